// File: rtl/pipe_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_reg_if -- handshake bundle for the pipe_reg valid/ready pipeline.
//
// Signals
//   flush      : synchronous invalidate of every stage
//   in_valid   : upstream item present
//   in_ready   : stage 0 can accept this cycle
//   in         : upstream data (BITS)
//   out_valid  : last stage holds a valid item
//   out_ready  : downstream accepts this cycle
//   out        : data of the last stage (BITS)
//   occupancy  : number of valid stages ($clog2(DEPTH+1) bits)
//
// Handshake rule: a transfer happens on a posedge where valid and ready are
// both high. A producer holds its data stable while valid=1 and ready=0.
// in_ready may depend combinationally on out_ready (ready pass-through).
//
// Modports
//   master : the side that drives items in and takes items out
//   slave  : the pipeline itself
// -----------------------------------------------------------------------------
interface pipe_reg_if #(
  parameter int BITS  = 1,
  parameter int DEPTH = 2
);
  localparam int OW = $clog2(DEPTH + 1);

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] in;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out;
  logic [OW-1:0]   occupancy;

  modport master (
    output flush, in_valid, in, out_ready,
    input  in_ready, out_valid, out, occupancy
  );

  modport slave (
    input  flush, in_valid, in, out_ready,
    output in_ready, out_valid, out, occupancy
  );
endinterface

// File: rtl/pipe_reg.sv
// -----------------------------------------------------------------------------
// pipe_reg -- DEPTH-stage valid/ready register pipeline with bubble collapse.
//
// Each stage i holds a valid bit v_q[i] and data d_q[i]. A stage loads from
// its upstream neighbour (stage 0 loads from the input) whenever it is ready,
// where ready means "empty, or everything ahead of it will move this cycle".
// This lets a stalled item slide into any empty slot ahead and lets in_ready
// pass straight through from out_ready when the pipe is full.
//
// Ports
//   clk : clock, all state updates on posedge
//   rst : synchronous active-high reset; clears valids, data <= RESET_VALUE
//   bus : pipe_reg_if.slave (flush, in/out handshakes, occupancy)
//
// Priority: rst > flush > transfers. A flush clears every valid bit but keeps
// data untouched; an input offered in the flush cycle is dropped, while an
// output taken in that cycle is still consumed exactly once.
// -----------------------------------------------------------------------------
module pipe_reg #(
  parameter int              BITS        = 1,
  parameter int              DEPTH       = 2,
  parameter logic [BITS-1:0] RESET_VALUE = '0
) (
  input  logic      clk,
  input  logic      rst,
  pipe_reg_if.slave bus
);
  localparam int OW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q, v_d;
  logic [BITS-1:0]  d_q [DEPTH];
  logic [BITS-1:0]  d_d [DEPTH];

  // rdy[i]: stage i may load this cycle. The ready of the stage past the end
  // is out_ready itself.
  logic [DEPTH-1:0] rdy;

  // Source of each stage: the input for stage 0, the previous stage otherwise.
  logic [DEPTH-1:0] src_v;
  logic [BITS-1:0]  src_d [DEPTH];

  logic [OW-1:0]    occ;

  assign src_v[0] = bus.in_valid;
  assign src_d[0] = bus.in;

  for (genvar g = 1; g < DEPTH; g++) begin : g_src
    assign src_v[g] = v_q[g-1];
    assign src_d[g] = d_q[g-1];
  end

  // Ready chain written as a running OR from the output end so each rdy bit
  // is a pure function of state and out_ready (no self-referencing vector).
  always_comb begin
    logic acc;
    acc = bus.out_ready;
    rdy = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc    = acc | ~v_q[i];
      rdy[i] = acc;
    end
  end

  // Next state. Bubbles loaded into a stage leave its data untouched.
  always_comb begin
    v_d = v_q;
    for (int i = 0; i < DEPTH; i++) begin
      d_d[i] = d_q[i];
      if (bus.flush) begin
        v_d[i] = 1'b0;
      end else if (rdy[i]) begin
        v_d[i] = src_v[i];
        if (src_v[i]) d_d[i] = src_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= RESET_VALUE;
    end else begin
      v_q <= v_d;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= d_d[i];
    end
  end

  // Population count of the registered valid bits.
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) occ = occ + OW'(v_q[i]);
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.out       = d_q[DEPTH-1];
  assign bus.occupancy = occ;
endmodule

// File: tb/tb_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_reg -- self-checking bench for pipe_reg (DEPTH=3, BITS=8,
// RESET_VALUE=8'hA5). The reference model keeps the in-flight items as a
// queue (oldest first) with the stage position of each item; every cycle the
// oldest item moves forward if the slot ahead is free, younger items follow
// into freed slots, and a new item enters at position 0.
// -----------------------------------------------------------------------------
module tb_pipe_reg;
  localparam int              BITS  = 8;
  localparam int              DEPTH = 3;
  localparam logic [BITS-1:0] RV    = 8'hA5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_reg_if #(.BITS(BITS), .DEPTH(DEPTH)) bus ();

  pipe_reg #(.BITS(BITS), .DEPTH(DEPTH), .RESET_VALUE(RV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard / model state ----------------
  logic [BITS-1:0] exp_q[$];   // in-flight items, oldest first
  int              pos_q[$];   // stage position of each in-flight item
  logic [BITS-1:0] m_last;     // data last written into the final stage
  int              n_chk  = 0;
  int              n_fail = 0;
  bit              check_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_out_valid();
    return (pos_q.size() > 0) && (pos_q[0] == DEPTH - 1);
  endfunction

  function automatic bit m_in_ready();
    return (pos_q.size() < DEPTH) || (bus.out_ready == 1'b1);
  endfunction

  task automatic check_outputs();
    chk("occupancy", 32'(bus.occupancy), 32'(pos_q.size()));
    chk("out_valid", 32'(bus.out_valid), 32'(m_out_valid()));
    chk("in_ready",  32'(bus.in_ready),  32'(m_in_ready()));
    chk("out",       32'(bus.out),       32'(m_last));
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit ov, ir;
    int lim;
    ov = m_out_valid();
    ir = m_in_ready();
    if (rst) begin
      exp_q.delete();
      pos_q.delete();
      m_last = RV;
      return;
    end
    if (ov && bus.out_ready) begin
      void'(exp_q.pop_front());
      void'(pos_q.pop_front());
    end
    if (bus.flush) begin
      exp_q.delete();
      pos_q.delete();
      return;
    end
    for (int k = 0; k < pos_q.size(); k++) begin
      lim = (k == 0) ? DEPTH : pos_q[k-1];
      if (pos_q[k] + 1 < lim) begin
        pos_q[k] = pos_q[k] + 1;
        if (pos_q[k] == DEPTH - 1) m_last = exp_q[k];
      end
    end
    if (bus.in_valid && ir) begin
      exp_q.push_back(bus.in);
      pos_q.push_back(0);
      if (DEPTH == 1) m_last = bus.in;
    end
  endtask

  // ---------------- driver tasks ----------------
  // One cycle: check outputs mid-cycle, update model, cross the edge.
  task automatic step();
    @(negedge clk);
    if (check_en) check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [BITS-1:0] d, input bit ordy);
    bus.in_valid  = v;
    bus.in        = d;
    bus.out_ready = ordy;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b1;
    bus.flush     = 1'b0;
    drive(1'b0, '0, 1'b0);
    m_last        = RV;

    // Reset
    step();
    rst      = 1'b0;
    check_en = 1'b1;
    chk("rst_out",       32'(bus.out),       32'(RV));
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_occ",       32'(bus.occupancy), 0);
    chk("rst_in_ready",  32'(bus.in_ready),  1);
    step();

    // Streaming: 01..04 back to back, DEPTH-cycle latency
    drive(1'b1, 8'h01, 1'b1); step();
    chk("lat_ov0", 32'(bus.out_valid), 0);
    drive(1'b1, 8'h02, 1'b1); step();
    chk("lat_ov1", 32'(bus.out_valid), 0);
    drive(1'b1, 8'h03, 1'b1); step();
    chk("lat_ov2", 32'(bus.out_valid), 1);
    chk("lat_out", 32'(bus.out), 32'h01);
    drive(1'b1, 8'h04, 1'b1); step();
    chk("stream_out2", 32'(bus.out), 32'h02);
    idle(1);
    chk("stream_out3", 32'(bus.out), 32'h03);
    idle(1);
    chk("stream_out4", 32'(bus.out), 32'h04);
    idle(3);

    // Fill and stall
    drive(1'b1, 8'h10, 1'b0); step();
    drive(1'b1, 8'h11, 1'b0); step();
    drive(1'b1, 8'h12, 1'b0); step();
    drive(1'b1, 8'h13, 1'b0);
    chk("stall_occ",      32'(bus.occupancy), 3);
    chk("stall_in_ready", 32'(bus.in_ready),  0);
    chk("stall_out",      32'(bus.out),       32'h10);
    step();
    chk("stall_hold_out", 32'(bus.out),       32'h10);
    bus.out_ready = 1'b1;
    #1;
    chk("pass_in_ready",  32'(bus.in_ready),  1);
    step();
    chk("after_pass_out", 32'(bus.out),       32'h11);
    idle(5);

    // Bubble collapse
    drive(1'b1, 8'h20, 1'b0); step();
    idle(2);
    drive(1'b1, 8'h21, 1'b0); step();
    idle(1);
    chk("bubble_occ", 32'(bus.occupancy), 2);
    chk("bubble_out", 32'(bus.out),       32'h20);
    idle(1);
    chk("bubble_hold_occ", 32'(bus.occupancy), 2);

    // Flush with a simultaneous input
    bus.flush = 1'b1;
    drive(1'b1, 8'h30, 1'b0); step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_occ", 32'(bus.occupancy), 0);
    chk("flush_ov",  32'(bus.out_valid), 0);
    bus.out_ready = 1'b1;
    idle(4);

    // Reset mid-stream
    drive(1'b1, 8'h40, 1'b0); step();
    drive(1'b1, 8'h41, 1'b0); step();
    drive(1'b1, 8'h42, 1'b0); step();
    chk("mid_occ_full", 32'(bus.occupancy), 3);
    drive(1'b0, 8'h00, 1'b1);
    rst = 1'b1; step();
    rst = 1'b0;
    chk("mid_rst_occ", 32'(bus.occupancy), 0);
    chk("mid_rst_out", 32'(bus.out),       32'(RV));
    chk("mid_rst_ov",  32'(bus.out_valid), 0);
    idle(2);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = ($urandom_range(0, 99) < 60);
      bus.in        = BITS'($urandom);
      bus.out_ready = ($urandom_range(0, 99) < 65);
      bus.flush     = ($urandom_range(0, 99) < 3);
      rst           = ($urandom_range(0, 199) < 1);
      step();
    end
    rst       = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
